hdma_regs_ctrl: RTL and testbench

CPU-facing front end for CGB VRAM DMA (0xFF51–0xFF55). Owns the HDMA1–HDMA5 register state, decodes general-purpose versus H-blank transfers, and paces H-blank DMA one 16-byte block per H-blank. It drives the DMA engine's register inputs and start pulse and consumes its finished pulse, which makes it the initiator side of the engine's start/finished handshake. It also returns HDMA5 status to the CPU and stalls the CPU during each block.

---
 rtl/hdma_regs_ctrl_pkg.sv | 26 ++
 rtl/hdma_regs_ctrl_hblank_edge_det.sv | 22 ++
 rtl/hdma_regs_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_hdma_regs_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdma_regs_ctrl_pkg.sv
// Shared types and constants for the CGB VRAM DMA register front end.
package hdma_regs_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GDMA_RUN,
    ST_HB_WAIT,
    ST_HB_XFER,
    ST_HB_HOLD
  } state_t;

  localparam logic [15:0] ADDR_HDMA1 = 16'hFF51;
  localparam logic [15:0] ADDR_HDMA2 = 16'hFF52;
  localparam logic [15:0] ADDR_HDMA3 = 16'hFF53;
  localparam logic [15:0] ADDR_HDMA4 = 16'hFF54;
  localparam logic [15:0] ADDR_HDMA5 = 16'hFF55;

  localparam logic [1:0]  PPU_MODE_HBLANK  = 2'b00;
  localparam int          HDMA_BLOCK_BYTES = 16;

  // Number of blocks encoded by a length field holding blocks-1.
  function automatic logic [7:0] blk_count(input logic [6:0] len);
    return {1'b0, len} + 8'd1;
  endfunction

endpackage

// File: rtl/hdma_regs_ctrl_hblank_edge_det.sv
// Flags the first cycle of an H-blank (mode entering 00 from another mode) while the LCD is on.
module hblank_edge_det
  import hdma_regs_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_ppu_mode,
  input  logic       i_lcd_en,
  output logic       o_rise
);

  logic [1:0] r_prev_mode;

  // Resetting to H-blank keeps a mode already at 00 out of reset from looking like an entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_prev_mode <= PPU_MODE_HBLANK;
    else         r_prev_mode <= i_ppu_mode;
  end

  assign o_rise = i_lcd_en && (i_ppu_mode == PPU_MODE_HBLANK) && (r_prev_mode != PPU_MODE_HBLANK);

endmodule

// File: rtl/hdma_regs_ctrl.sv
// CGB VRAM DMA register front end (FF51-FF55): GDMA, and H-blank DMA paced one block per H-blank.
// H-blank mode exists only with HDMA_HBLANK_EN defined; without it every FF55 write starts a GDMA.
module hdma_regs_ctrl
  import hdma_regs_ctrl_pkg::*;
(
  input  logic        i_clk4_2,
  input  logic        i_reset,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_wr_en,
  input  logic [7:0]  i_cpu_wr_data,
  output logic [7:0]  o_cpu_rd_data,
  input  logic [1:0]  i_ppu_mode,
  input  logic        i_lcd_en,
  input  logic        i_dma_finished,
  output logic [7:0]  o_hdma1_out,
  output logic [7:0]  o_hdma2_out,
  output logic [7:0]  o_hdma3_out,
  output logic [7:0]  o_hdma4_out,
  output logic [7:0]  o_hdma5_out,
  output logic        o_dma_start,
  output logic        o_cpu_stall,
  output logic        o_hdma_active
);

  // Pointers keep only the bits above the 16-byte block offset, which is always zero.
  state_t      r_state;
  logic [15:4] r_src;
  logic [12:4] r_dst;
  logic [6:0]  r_len;
  logic        r_cancelled;
  logic        r_dma_start;
  logic        r_cpu_stall;

  state_t      w_state;
  logic [15:4] w_src;
  logic [12:4] w_dst;
  logic [6:0]  w_len;
  logic        w_fin;
  logic        w_wr_len;
  logic        w_active;

  assign w_wr_len = i_cpu_wr_en && (i_cpu_addr == ADDR_HDMA5);

`ifdef HDMA_HBLANK_EN
  logic w_rise;

  hblank_edge_det u_edge (
    .i_clk      (i_clk4_2),
    .i_reset    (i_reset),
    .i_ppu_mode (i_ppu_mode),
    .i_lcd_en   (i_lcd_en),
    .o_rise     (w_rise)
  );

  assign w_active = (r_state == ST_HB_WAIT) || (r_state == ST_HB_XFER) || (r_state == ST_HB_HOLD);
`else
  logic w_unused_hb;
  assign w_unused_hb = ^{i_ppu_mode, i_lcd_en};
  assign w_active    = 1'b0;
`endif

  // Effect of engine completion and H-blank pacing; a same-cycle CPU write is applied on top.
  always_comb begin
    w_state = r_state;
    w_src   = r_src;
    w_dst   = r_dst;
    w_len   = r_len;
    w_fin   = 1'b0;
    if (i_dma_finished && (r_state == ST_GDMA_RUN)) begin
      w_src   = r_src + {4'h0, blk_count(r_len)};
      w_dst   = r_dst + {1'b0, blk_count(r_len)};
      w_len   = 7'h7F;
      w_state = ST_IDLE;
      w_fin   = 1'b1;
    end
`ifdef HDMA_HBLANK_EN
    else if (i_dma_finished && (r_state == ST_HB_XFER)) begin
      w_src = r_src + 12'd1;
      w_dst = r_dst + 9'd1;
      w_fin = 1'b1;
      if (r_len == 7'd0) begin
        w_len   = 7'h7F;
        w_state = ST_IDLE;
      end else begin
        w_len   = r_len - 7'd1;
        w_state = ST_HB_HOLD;
      end
    end else if ((r_state == ST_HB_HOLD) && ((i_ppu_mode != PPU_MODE_HBLANK) || !i_lcd_en)) begin
      w_state = ST_HB_WAIT;
    end
`endif
  end

  always_ff @(posedge i_clk4_2) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= 7'h7F;
      r_cancelled <= 1'b0;
      r_dma_start <= 1'b0;
      r_cpu_stall <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_src       <= w_src;
      r_dst       <= w_dst;
      r_len       <= w_len;
      r_dma_start <= 1'b0;
      if (w_fin) r_cpu_stall <= 1'b0;

      if (i_cpu_wr_en && (w_state == ST_IDLE)) begin
        case (i_cpu_addr)
          ADDR_HDMA1: r_src[15:8] <= i_cpu_wr_data;
          ADDR_HDMA2: r_src[7:4]  <= i_cpu_wr_data[7:4];
          ADDR_HDMA3: r_dst[12:8] <= i_cpu_wr_data[4:0];
          ADDR_HDMA4: r_dst[7:4]  <= i_cpu_wr_data[7:4];
          default: ;
        endcase
      end

      if (w_wr_len) begin
        r_cancelled <= 1'b0;
        case (w_state)
          ST_IDLE: begin
            r_len <= i_cpu_wr_data[6:0];
`ifdef HDMA_HBLANK_EN
            if (!i_cpu_wr_data[7]) begin
              r_state     <= ST_GDMA_RUN;
              r_dma_start <= 1'b1;
              r_cpu_stall <= 1'b1;
            end else if (i_lcd_en) begin
              r_state <= ST_HB_WAIT;
            end else begin
              // With the LCD off no H-blank will come, so the first block goes now.
              r_state     <= ST_HB_XFER;
              r_dma_start <= 1'b1;
              r_cpu_stall <= 1'b1;
            end
`else
            r_state     <= ST_GDMA_RUN;
            r_dma_start <= 1'b1;
            r_cpu_stall <= 1'b1;
`endif
          end
`ifdef HDMA_HBLANK_EN
          ST_HB_WAIT, ST_HB_HOLD: begin
            if (i_cpu_wr_data[7]) begin
              r_len <= i_cpu_wr_data[6:0];
            end else begin
              r_cancelled <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
`endif
          default: ;
        endcase
      end
`ifdef HDMA_HBLANK_EN
      else if ((r_state == ST_HB_WAIT) && w_rise) begin
        r_state     <= ST_HB_XFER;
        r_dma_start <= 1'b1;
        r_cpu_stall <= 1'b1;
      end
`endif
    end
  end

  always_comb begin
    o_cpu_rd_data = 8'h00;
    case (i_cpu_addr)
      ADDR_HDMA1, ADDR_HDMA2, ADDR_HDMA3, ADDR_HDMA4: o_cpu_rd_data = 8'hFF;
      ADDR_HDMA5: begin
        if (r_state != ST_IDLE) o_cpu_rd_data = {1'b0, r_len};
        else if (r_cancelled)   o_cpu_rd_data = {1'b1, r_len};
        else                    o_cpu_rd_data = 8'hFF;
      end
      default: ;
    endcase
  end

  assign o_hdma1_out   = r_src[15:8];
  assign o_hdma2_out   = {r_src[7:4], 4'h0};
  assign o_hdma3_out   = {3'b000, r_dst[12:8]};
  assign o_hdma4_out   = {r_dst[7:4], 4'h0};
  // H-blank blocks are started one at a time, so the engine always sees a single-block length.
  assign o_hdma5_out   = w_active ? 8'h00 : {(r_state == ST_IDLE), r_len};
  assign o_dma_start   = r_dma_start;
  assign o_cpu_stall   = r_cpu_stall;
  assign o_hdma_active = w_active;

endmodule

// File: tb/tb_hdma_regs_ctrl.sv
// Randomized bench for hdma_regs_ctrl against a transaction-level model of pointers, length and FF55 status.
module tb_hdma_regs_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic        wr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [1:0]  mode;
  logic        lcd;
  logic        fin;
  logic [7:0]  h1, h2, h3, h4, h5;
  logic        dstart, stall, active;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] m_src;
  logic [15:0] m_dst;

  hdma_regs_ctrl dut (
    .i_clk4_2       (clk),
    .i_reset        (rst),
    .i_cpu_addr     (addr),
    .i_cpu_wr_en    (wr),
    .i_cpu_wr_data  (wdata),
    .o_cpu_rd_data  (rdata),
    .i_ppu_mode     (mode),
    .i_lcd_en       (lcd),
    .i_dma_finished (fin),
    .o_hdma1_out    (h1),
    .o_hdma2_out    (h2),
    .o_hdma3_out    (h3),
    .o_hdma4_out    (h4),
    .o_hdma5_out    (h5),
    .o_dma_start    (dstart),
    .o_cpu_stall    (stall),
    .o_hdma_active  (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    addr = a; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    chk(tag, {8'h00, rdata}, {8'h00, exp});
  endtask

  task automatic chk_ptrs(input string tag);
    chk({tag, "_src"}, {h1, h2}, m_src);
    chk({tag, "_dst"}, {h3, h4}, m_dst);
  endtask

  // Each block moves 16 bytes; destination lives in a 8 KiB window.
  task automatic model_advance(input int blocks);
    m_src = m_src + 16'(blocks * 16);
    m_dst = (m_dst + 16'(blocks * 16)) & 16'h1FF0;
  endtask

  task automatic set_ptrs(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    cpu_wr(16'hFF51, b1);
    cpu_wr(16'hFF52, b2);
    cpu_wr(16'hFF53, b3);
    cpu_wr(16'hFF54, b4);
    m_src = {b1, b2[7:4], 4'h0};
    m_dst = {3'b000, b3[4:0], b4[7:4], 4'h0};
  endtask

  // Called the cycle DMA_start should be visible; plays the engine for one block.
  task automatic run_block(input logic [7:0] exp5, input bit poke);
    bit spur = 1'b0;
    bit held = 1'b1;
    chk("start_pulse", {15'd0, dstart}, 16'd1);
    chk("blk_hdma5", {8'h00, h5}, {8'h00, exp5});
    chk("stall_rise", {15'd0, stall}, 16'd1);
    chk_ptrs("blk_ptr");
    if (poke) begin
      cpu_wr(16'hFF51, ~m_src[15:8]);
      spur |= dstart; held &= stall;
      cpu_wr(16'hFF55, 8'h00);
      spur |= dstart; held &= stall;
    end
    repeat ($urandom_range(1, 5)) begin
      tick();
      spur |= dstart; held &= stall;
    end
    chk("single_start", {15'd0, spur}, 16'd0);
    chk("stall_held", {15'd0, held}, 16'd1);
    chk("blk_hdma5_hold", {8'h00, h5}, {8'h00, exp5});
    chk_ptrs("blk_ptr_hold");
    fin = 1'b1;
    tick();
    fin = 1'b0;
    chk("stall_fall", {15'd0, stall}, 16'd0);
  endtask

  task automatic gdma(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                      input logic [7:0] b4, input logic [7:0] ctl, input bit poke);
    set_ptrs(b1, b2, b3, b4);
    cpu_wr(16'hFF55, ctl);
    rd_chk("gdma_rd_run", 16'hFF55, {1'b0, ctl[6:0]});
    run_block({1'b0, ctl[6:0]}, poke);
    model_advance(int'(ctl[6:0]) + 1);
    rd_chk("gdma_rd_done", 16'hFF55, 8'hFF);
    chk_ptrs("gdma_post");
    chk("gdma_hdma5_idle", {8'h00, h5}, 16'h00FF);
    chk("gdma_active", {15'd0, active}, 16'd0);
  endtask

`ifdef HDMA_HBLANK_EN
  // One H-blank: a non-zero mode gap, entry to mode 0, the block, then lingering in mode 0.
  task automatic hb_block(input bit poke);
    bit spur = 1'b0;
    mode = 2'($urandom_range(1, 3));
    repeat ($urandom_range(1, 4)) begin
      tick();
      spur |= dstart;
    end
    chk("hb_no_early_start", {15'd0, spur}, 16'd0);
    mode = 2'b00;
    tick();
    run_block(8'h00, poke);
    model_advance(1);
    spur = 1'b0;
    repeat ($urandom_range(1, 4)) begin
      tick();
      spur |= dstart;
    end
    chk("hb_hold_no_start", {15'd0, spur}, 16'd0);
  endtask

  task automatic hb_run(input logic [6:0] len);
    logic [6:0] rem;
    cpu_wr(16'hFF55, {1'b1, len});
    chk("hb_arm_no_start", {15'd0, dstart}, 16'd0);
    chk("hb_arm_active", {15'd0, active}, 16'd1);
    for (int b = 0; b <= int'(len); b++) begin
      rem = len - 7'(b);
      rd_chk("hb_rd_len", 16'hFF55, {1'b0, rem});
      hb_block(b == 0);
    end
    rd_chk("hb_rd_done", 16'hFF55, 8'hFF);
    chk("hb_done_active", {15'd0, active}, 16'd0);
    chk_ptrs("hb_post");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d0;
    bit spur;
    rst = 1'b1; addr = 16'h0000; wr = 1'b0; wdata = 8'h00;
    mode = 2'd3; lcd = 1'b1; fin = 1'b0;
    m_src = 16'h0000; m_dst = 16'h0000;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk_ptrs("rst_ptr");
    chk("rst_hdma5", {8'h00, h5}, 16'h00FF);
    chk("rst_start", {15'd0, dstart}, 16'd0);
    chk("rst_stall", {15'd0, stall}, 16'd0);
    chk("rst_active", {15'd0, active}, 16'd0);
    rd_chk("rst_rd55", 16'hFF55, 8'hFF);
    rd_chk("rd51", 16'hFF51, 8'hFF);
    rd_chk("rd53", 16'hFF53, 8'hFF);
    rd_chk("rd_other", 16'h1234, 8'h00);

    gdma(8'hC0, 8'h00, 8'h80, 8'h00, 8'h03, 1'b0);
    chk("tp_gdma_src", {h1, h2}, 16'hC040);

    // 128 blocks from the top of both address spaces: both pointers wrap.
    gdma(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 1'b1);
    chk("wrap_src", {h1, h2}, 16'h07F0);
    chk("wrap_dst", {h3, h4}, 16'h07F0);

    for (int k = 0; k < 8; k++) begin
`ifdef HDMA_HBLANK_EN
      gdma(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom) & 8'h7F, k[0]);
`else
      gdma(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), k[0]);
`endif
    end

`ifdef HDMA_HBLANK_EN
    set_ptrs(8'h12, 8'h30, 8'h05, 8'h40);
    d0 = m_dst;
    hb_run(7'd1);
    chk("tp_hb_dst", {h3, h4}, (d0 + 16'h0020) & 16'h1FFF);

    for (int k = 0; k < 3; k++) begin
      set_ptrs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      hb_run(7'($urandom_range(0, 3)));
    end

    // Cancel after one block: status keeps the remaining length with bit 7 set.
    set_ptrs(8'h40, 8'h00, 8'h1F, 8'hE0);
    cpu_wr(16'hFF55, 8'h85);
    hb_block(1'b0);
    cpu_wr(16'hFF55, 8'h00);
    rd_chk("cancel_rd", 16'hFF55, 8'h84);
    chk("cancel_active", {15'd0, active}, 16'd0);
    spur = 1'b0;
    repeat (2) begin
      mode = 2'd3; tick(); spur |= dstart; tick(); spur |= dstart;
      mode = 2'd0; tick(); spur |= dstart; tick(); spur |= dstart;
    end
    chk("cancel_no_start", {15'd0, spur}, 16'd0);
    chk_ptrs("cancel_ptr");

    // A cancel landing on the H-blank entry wins over the block start.
    mode = 2'd3;
    cpu_wr(16'hFF55, 8'h82);
    mode = 2'd0;
    cpu_wr(16'hFF55, 8'h00);
    chk("race_no_start", {15'd0, dstart}, 16'd0);
    tick();
    chk("race_no_start2", {15'd0, dstart}, 16'd0);
    rd_chk("race_rd", 16'hFF55, 8'h82);
    chk_ptrs("race_ptr");

    lcd = 1'b0;
    mode = 2'd3;
    cpu_wr(16'hFF55, 8'h80);
    run_block(8'h00, 1'b0);
    model_advance(1);
    rd_chk("lcdoff_rd", 16'hFF55, 8'hFF);
    chk_ptrs("lcdoff_ptr");
    lcd = 1'b1;
`else
    // Without H-blank support bit 7 is ignored and a GDMA runs.
    gdma(8'h80, 8'h00, 8'h00, 8'h00, 8'h81, 1'b0);
    chk("nohb_active", {15'd0, active}, 16'd0);
    lcd = 1'b0;
    gdma(8'h81, 8'h10, 8'h01, 8'h20, 8'h80, 1'b0);
    lcd = 1'b1;
`endif

    // Reset in the middle of a GDMA; a late finished pulse must not move anything.
    set_ptrs(8'hA5, 8'h50, 8'h0C, 8'h30);
    cpu_wr(16'hFF55, 8'h10);
    chk("rst_mid_start", {15'd0, dstart}, 16'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_src = 16'h0000;
    m_dst = 16'h0000;
    chk("rst_mid_stall", {15'd0, stall}, 16'd0);
    chk("rst_mid_hdma5", {8'h00, h5}, 16'h00FF);
    chk("rst_mid_active", {15'd0, active}, 16'd0);
    rd_chk("rst_mid_rd", 16'hFF55, 8'hFF);
    fin = 1'b1;
    tick();
    fin = 1'b0;
    tick();
    chk_ptrs("rst_late_fin");
    chk("rst_late_stall", {15'd0, stall}, 16'd0);
    rd_chk("rst_late_rd", 16'hFF55, 8'hFF);

    gdma(8'h01, 8'h20, 8'h02, 8'h30, 8'h02, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
